// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame geometry
// and the baud divider derivation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_recv_multi_if.sv
// Receiver-side bundle: serial input, assembled word, status strobes and FSM state.
interface uart_recv_multi_if #(
    parameter int DATAWIDTH = 16
);
    import uart_pkg::*;

    // No back-pressure: uart_data is valid in the cycle uart_done is high and
    // holds until the next completed word; the consumer must accept the strobe.
    logic                 uart_rxd;
    logic [DATAWIDTH-1:0] uart_data;
    logic                 uart_done;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 rx_timeout;
    uart_state_t          state_dbg;

    modport master (
        input  uart_rxd,
        output uart_data,
        output uart_done,
        output rx_busy,
        output frame_err,
        output rx_timeout,
        output state_dbg
    );

    modport slave (
        output uart_rxd,
        input  uart_data,
        input  uart_done,
        input  rx_busy,
        input  frame_err,
        input  rx_timeout,
        input  state_dbg
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus falling-edge detect.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rxd,
    output logic rxd_s,
    output logic start_edge
);

    logic d0;
    logic d1;
    logic d2;

    // Reset to the idle-high line level so release of reset is not a start edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d0 <= 1'b1;
            d1 <= 1'b1;
            d2 <= 1'b1;
        end else begin
            d0 <= rxd;
            d1 <= d0;
            d2 <= d1;
        end
    end

    assign rxd_s      = d1;
    assign start_edge = d2 & ~d1;

endmodule

// File: rtl/uart_recv_multi.sv
// 8N1 UART receiver that assembles CNT_NUM bytes, LSB byte first, into one word
// with a one-cycle done strobe, frame-error and inter-byte timeout reporting.
module uart_recv_multi
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 200000000,
    parameter int UART_BPS     = 115200,
    parameter int DATAWIDTH    = 16,
    parameter int CNT_NUM      = 2,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    uart_recv_multi_if.master  rx_if
);

    localparam int BPS_CNT     = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CNT_W       = $clog2(BPS_CNT);
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * BPS_CNT;
    localparam int IDLE_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W       = (CNT_NUM > 1) ? $clog2(CNT_NUM) : 1;

    localparam logic [CNT_W-1:0]  SAMPLE_CNT = CNT_W'(BPS_CNT / 2);
    localparam logic [CNT_W-1:0]  BIT_END    = CNT_W'(BPS_CNT - 1);
    localparam logic [IDLE_W-1:0] IDLE_END   = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(CNT_NUM - 1);
    localparam logic [2:0]        LAST_BIT   = 3'(FRAME_BITS - 3);

    logic rxd_s;
    logic start_edge;

    uart_state_t          state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift_reg;
    logic [IDX_W-1:0]     byte_idx;
    logic [DATAWIDTH-1:0] assembly;
    logic [DATAWIDTH-1:0] word_next;
    logic [IDLE_W-1:0]    idle_cnt;
    logic                 timeout_hit;

    logic [DATAWIDTH-1:0] data_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 ferr_q;
    logic                 tout_q;

    uart_rx_sync u_sync (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rxd        (rx_if.uart_rxd),
        .rxd_s      (rxd_s),
        .start_edge (start_edge)
    );

    // Assembly with the just-received byte merged into its lane
    always_comb begin
        word_next = assembly;
        for (int i = 0; i < CNT_NUM; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                word_next[8*i +: 8] = shift_reg;
            end
        end
    end

    assign timeout_hit = (state == IDLE) && (byte_idx != '0) && (idle_cnt == IDLE_END);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            byte_idx  <= '0;
            assembly  <= '0;
            idle_cnt  <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            tout_q <= 1'b0;

            // Inter-byte idle counter: only meaningful with a partial word pending
            if (state == IDLE && byte_idx != '0 && !start_edge && !timeout_hit) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    // Timeout takes priority; a coincident start edge lands in lane 0
                    if (timeout_hit) begin
                        tout_q   <= 1'b1;
                        byte_idx <= '0;
                        assembly <= '0;
                    end
                    if (start_edge) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt == SAMPLE_CNT && rxd_s) begin
                        state   <= IDLE;
                        clk_cnt <= '0;
                        busy_q  <= 1'b0;
                    end else if (clk_cnt == BIT_END) begin
                        state   <= DATA;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (clk_cnt == SAMPLE_CNT) begin
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                    end
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    // Leave at mid-stop so a shortened stop bit is tolerated
                    if (clk_cnt == SAMPLE_CNT) begin
                        state   <= IDLE;
                        clk_cnt <= '0;
                        busy_q  <= 1'b0;
                        if (rxd_s) begin
                            assembly <= word_next;
                            if (byte_idx == LAST_IDX) begin
                                data_q   <= word_next;
                                done_q   <= 1'b1;
                                byte_idx <= '0;
                            end else begin
                                byte_idx <= byte_idx + IDX_W'(1);
                            end
                        end else begin
                            ferr_q   <= 1'b1;
                            byte_idx <= '0;
                            assembly <= '0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.uart_data  = data_q;
    assign rx_if.uart_done  = done_q;
    assign rx_if.rx_busy    = busy_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.rx_timeout = tout_q;
    assign rx_if.state_dbg  = state;

endmodule

// File: tb/tb_uart_recv_multi.sv
// Bench for uart_recv_multi: serial driver tasks, word scoreboard, scenario tasks.
module tb_uart_recv_multi;
    import uart_pkg::*;

    localparam int CLK_FREQ     = 1600000;
    localparam int UART_BPS     = 100000;
    localparam int BPS          = 16;
    localparam int DW           = 16;
    localparam int CNT_NUM      = 2;
    localparam int TIMEOUT_BITS = 20;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    always #5 sys_clk = ~sys_clk;

    uart_recv_multi_if #(.DATAWIDTH(DW)) rx_if ();

    uart_recv_multi #(
        .CLK_FREQ     (CLK_FREQ),
        .UART_BPS     (UART_BPS),
        .DATAWIDTH    (DW),
        .CNT_NUM      (CNT_NUM),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_if     (rx_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int ferr_cnt     = 0;
    int tout_cnt     = 0;
    int busy_cyc     = 0;

    logic [DW-1:0] exp_q[$];

    // Scoreboard and pulse monitor, sampled on the falling edge
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_if.uart_done) begin
                logic [DW-1:0] exp_word;
                done_cnt++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_done: got data %h, expected no word", rx_if.uart_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (rx_if.uart_data !== exp_word) begin
                        tests_failed++;
                        $display("FAIL word_data: got %h expected %h", rx_if.uart_data, exp_word);
                    end
                end
            end
            if (rx_if.frame_err)  ferr_cnt++;
            if (rx_if.rx_timeout) tout_cnt++;
            if (rx_if.rx_busy)    busy_cyc++;
            if (rx_if.uart_done || rx_if.frame_err || rx_if.rx_timeout) begin
                tests_run++;
                if (32'(rx_if.uart_done) + 32'(rx_if.frame_err) + 32'(rx_if.rx_timeout) > 1) begin
                    tests_failed++;
                    $display("FAIL pulse_exclusive: done=%b ferr=%b tout=%b, expected at most one",
                             rx_if.uart_done, rx_if.frame_err, rx_if.rx_timeout);
                end
            end
        end
    end

    // All driver tasks are entered and left on a falling edge
    task automatic drive_level(input logic lvl, input int cyc);
        rx_if.uart_rxd = lvl;
        repeat (cyc) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input int stop_len);
        drive_level(1'b0, BPS);
        for (int i = 0; i < 8; i++) drive_level(b[i], BPS);
        drive_level(stop_lvl, stop_len);
        rx_if.uart_rxd = 1'b1;
    endtask

    task automatic test_reset;
        rx_if.uart_rxd = 1'b1;
        #2 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        tests_run += 5;
        if (rx_if.uart_data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", rx_if.uart_data); end
        if (rx_if.uart_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", rx_if.uart_done); end
        if (rx_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", rx_if.rx_busy); end
        if (rx_if.frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b expected 0", rx_if.frame_err); end
        if (rx_if.rx_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_tout: got %b expected 0", rx_if.rx_timeout); end
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_two_bytes;
        int d0 = done_cnt;
        exp_q.push_back(16'h1234);
        send_byte(8'h34, 1'b1, BPS);
        tests_run++;
        if (rx_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL gap_busy: got %b expected 0", rx_if.rx_busy); end
        drive_level(1'b1, 4);
        send_byte(8'h12, 1'b1, BPS);
        repeat (20) @(negedge sys_clk);
        tests_run += 2;
        if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL two_bytes_done_count: got %0d expected 1", done_cnt - d0); end
        if (rx_if.uart_data !== 16'h1234) begin tests_failed++; $display("FAIL two_bytes_hold: got %h expected 1234", rx_if.uart_data); end
    endtask

    task automatic test_glitch;
        int b0 = busy_cyc;
        int p0 = done_cnt + ferr_cnt + tout_cnt;
        drive_level(1'b0, 4);
        drive_level(1'b1, 30);
        tests_run += 3;
        if (busy_cyc - b0 < 1 || busy_cyc - b0 > 9) begin
            tests_failed++; $display("FAIL glitch_busy_cycles: got %0d expected 1..9", busy_cyc - b0);
        end
        if (rx_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_end: got %b expected 0", rx_if.rx_busy); end
        if (done_cnt + ferr_cnt + tout_cnt != p0) begin
            tests_failed++; $display("FAIL glitch_pulses: got %0d extra pulses expected 0", done_cnt + ferr_cnt + tout_cnt - p0);
        end
    endtask

    task automatic test_frame_err;
        int f0 = ferr_cnt;
        int d0 = done_cnt;
        send_byte(8'h77, 1'b0, BPS);
        drive_level(1'b1, BPS);
        tests_run += 2;
        if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL frame_err_count: got %0d expected 1", ferr_cnt - f0); end
        if (rx_if.uart_data !== 16'h1234) begin tests_failed++; $display("FAIL frame_err_data: got %h expected 1234", rx_if.uart_data); end
        exp_q.push_back(16'h55AA);
        send_byte(8'hAA, 1'b1, BPS);
        drive_level(1'b1, 4);
        send_byte(8'h55, 1'b1, BPS);
        repeat (20) @(negedge sys_clk);
        tests_run++;
        if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL after_ferr_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_timeout;
        int t0 = tout_cnt;
        int d0 = done_cnt;
        send_byte(8'h11, 1'b1, BPS);
        drive_level(1'b1, 19 * BPS);
        tests_run++;
        if (tout_cnt != t0) begin tests_failed++; $display("FAIL timeout_early: got %0d pulses expected 0", tout_cnt - t0); end
        drive_level(1'b1, 2 * BPS);
        tests_run++;
        if (tout_cnt - t0 != 1) begin tests_failed++; $display("FAIL timeout_count: got %0d expected 1", tout_cnt - t0); end
        exp_q.push_back(16'hABCD);
        send_byte(8'hCD, 1'b1, BPS);
        drive_level(1'b1, 4);
        send_byte(8'hAB, 1'b1, BPS);
        repeat (20) @(negedge sys_clk);
        tests_run++;
        if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL after_timeout_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        int d0 = done_cnt;
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'h0001);
        send_byte(8'hEF, 1'b1, BPS - 1);
        send_byte(8'hBE, 1'b1, BPS - 1);
        send_byte(8'h01, 1'b1, BPS - 1);
        send_byte(8'h00, 1'b1, BPS - 1);
        repeat (20) @(negedge sys_clk);
        tests_run += 2;
        if (done_cnt - d0 != 2) begin tests_failed++; $display("FAIL loopback_done_count: got %0d expected 2", done_cnt - d0); end
        if (rx_if.uart_data !== 16'h0001) begin tests_failed++; $display("FAIL loopback_last: got %h expected 0001", rx_if.uart_data); end
    endtask

    task automatic test_reset_mid;
        int d0;
        drive_level(1'b0, BPS);
        drive_level(1'b1, BPS);
        drive_level(1'b0, 5);
        sys_rst_n = 1'b0;
        #1;
        tests_run += 4;
        if (rx_if.uart_data !== '0) begin tests_failed++; $display("FAIL midreset_data: got %h expected 0", rx_if.uart_data); end
        if (rx_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b expected 0", rx_if.rx_busy); end
        if (rx_if.state_dbg !== IDLE) begin tests_failed++; $display("FAIL midreset_state: got %0d expected %0d", rx_if.state_dbg, IDLE); end
        if ({rx_if.uart_done, rx_if.frame_err, rx_if.rx_timeout} !== 3'b000) begin
            tests_failed++; $display("FAIL midreset_pulses: got %b expected 000", {rx_if.uart_done, rx_if.frame_err, rx_if.rx_timeout});
        end
        @(negedge sys_clk);
        rx_if.uart_rxd = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        d0 = done_cnt;
        exp_q.push_back(16'h0102);
        send_byte(8'h02, 1'b1, BPS);
        drive_level(1'b1, $urandom_range(2, 12));
        send_byte(8'h01, 1'b1, BPS);
        repeat (20) @(negedge sys_clk);
        tests_run += 2;
        if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL after_reset_done: got %0d expected 1", done_cnt - d0); end
        if (rx_if.uart_data !== 16'h0102) begin tests_failed++; $display("FAIL after_reset_data: got %h expected 0102", rx_if.uart_data); end
    endtask

    initial begin
        rx_if.uart_rxd = 1'b1;
        @(negedge sys_clk);
        test_reset();
        test_two_bytes();
        test_glitch();
        test_frame_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d words pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
